result_streamer: RTL
====================

// Module: result_streamer
// PURPOSE
//  Output stage downstream of the 2x2 systolic array. On a capture strobe it snapshots
//  the four accumulator results (c00,c01,c10,c11), optionally applies ReLU and signed
//  8-bit saturation, then streams them out byte-by-byte over a valid/ready handshake.
//  Lets the host read a full result tile at its own pace, independent of the mem_addr
//  readout sequence.
// PARAMETERS
//  ACC_W   16  accumulator width per result, signed two's complement
//  OUT_W    8  width of the output byte stream; fixed at 8 (ACC_W == 2*OUT_W required)
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  rst        in   1      asynchronous reset, active-high
//  capture    in   1      snapshot request; sampled on clk
//  relu_en    in   1      sampled with capture: clamp negative results to 0
//  sat_en     in   1      sampled with capture: 1 byte/result, saturated to [-128,127]
//  c00..c11   in   ACC_W  array results, each a separate port; sampled on capture
//  out_ready  in   1      consumer can accept a byte this cycle
//  out_data   out  OUT_W  current byte
//  out_valid  out  1      out_data holds a valid byte
//  out_last   out  1      current byte is the final byte of the tile
//  busy       out  1      tile held, not yet fully transferred
//  overflow   out  1      1-cycle pulse: capture dropped because streamer was busy
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; snapshot registers 0; byte index 0.
//  States: IDLE (out_valid=0, busy=0) and STREAM (out_valid=1, busy=1).
//  IDLE + capture=1: on that edge latch c00,c01,c10,c11 (post-ReLU), relu_en, sat_en;
//    go to STREAM. out_valid=1 with byte 0 from the next cycle (latency 1 cycle).
//  ReLU: if relu_en and result[ACC_W-1]=1, the result becomes 0. Applied before saturation.
//  sat_en=0: 8 bytes, order c00[15:8],c00[7:0],c01 hi,c01 lo,c10 hi,c10 lo,c11 hi,c11 lo.
//  sat_en=1: 4 bytes c00,c01,c10,c11. Each is >127 -> 8'h7F, <-128 -> 8'h80, else [7:0].
//  Transfer occurs on an edge with out_valid & out_ready. The index then advances.
//    out_valid=1 & out_ready=0: out_data/out_last held stable. No timeout.
//  out_last=1 exactly while the final byte (index 7, or 3 if sat_en) is presented.
//  Final-byte transfer with capture=0: -> IDLE. out_valid/busy/out_last low next cycle.
//  Final-byte transfer with capture=1: back-to-back. New tile is latched on the same edge.
//    Stay in STREAM. Byte 0 of the new tile is presented next cycle (no bubble).
//  capture=1 in STREAM, not on a final-byte transfer: ignored. Snapshot is unchanged.
//    overflow=1 for the following cycle only.
//  c*, relu_en and sat_en changing during STREAM: no effect on the tile in flight.
//  Reset asserted mid-stream: outputs go to 0 immediately (async). The partial tile is discarded.
//    After release, the block is in IDLE and waits for a new capture.
//  Output values come from registers only. No combinational path from out_ready to out_valid.
// TESTING
//  1 Reset, then hold idle 5 cycles -> out_valid, busy, overflow, out_data all 0.
//  2 c00=16'h1234,c01=16'hFF80,c10=16'h0001,c11=16'h7FFF. Pulse capture, sat_en=0, relu_en=0.
//    Hold out_ready=1 -> bytes 12,34,FF,80,00,01,7F,FF on 8 consecutive cycles.
//    out_last is set on the FF byte. Idle after that.
//  3 Same inputs with sat_en=1, relu_en=1 -> 4 bytes 7F,00,01,7F. out_last on the 4th byte.
//    c01 (negative) is zeroed by ReLU.
//  4 Toggle out_ready randomly (about 50%) in mode 2 -> each byte is seen exactly once, in order.
//    out_data is stable during stalls. Change c* mid-stream -> output is unaffected.
//  5 Pulse capture mid-stream -> overflow=1 for 1 cycle and the tile is unchanged.
//    Assert capture on the final-byte transfer -> next tile starts with no idle cycle.
//  6 Assert rst at byte 3 of a stream -> outputs are 0 at once.
//    After release and a new capture -> a full, correct 8-byte tile.

Source files
------------

// File: rtl/result_streamer.sv
// ---------------------------------------------------------------------------
// result_streamer
//
// Output stage for the 2x2 systolic array. When capture is pulsed, it takes a
// snapshot of the four accumulator results c00, c01, c10 and c11. ReLU can be
// applied to the results before they are stored. The tile is then streamed out
// one byte at a time over a valid/ready handshake, so the host can read it at
// its own pace.
//
// Output modes:
//   sat_en = 0 : 8 bytes, high byte then low byte, in the order c00, c01, c10, c11
//   sat_en = 1 : 4 bytes, each result saturated to the signed 8-bit range
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   capture    in   1      snapshot request
//   relu_en    in   1      clamp negative results to 0 (sampled with capture)
//   sat_en     in   1      saturated 1-byte-per-result mode (sampled with capture)
//   c00..c11   in   ACC_W  array results (sampled with capture)
//   out_ready  in   1      consumer accepts a byte this cycle
//   out_data   out  OUT_W  current byte (0 when not valid)
//   out_valid  out  1      out_data holds a valid byte
//   out_last   out  1      current byte is the final byte of the tile
//   busy       out  1      a tile is held and not yet fully transferred
//   overflow   out  1      one-cycle pulse: capture dropped while busy
//
// ACC_W must equal 2*OUT_W so that one result splits into exactly two bytes.
// ---------------------------------------------------------------------------
module result_streamer #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             relu_en,
    input  logic             sat_en,
    input  logic [ACC_W-1:0] c00,
    input  logic [ACC_W-1:0] c01,
    input  logic [ACC_W-1:0] c10,
    input  logic [ACC_W-1:0] c11,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Saturation limits, written at the accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    state_t                       state_q, state_d;
    logic [3:0][ACC_W-1:0]        snap_q, snap_d;
    logic                         sat_q, sat_d;
    logic [2:0]                   idx_q, idx_d;
    logic                         overflow_q, overflow_d;

    logic                         streaming;
    logic                         isLast;
    logic                         latchTile;
    logic [1:0]                   sel;
    logic [ACC_W-1:0]             curResult;
    logic [OUT_W-1:0]             curByte;

    function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v, input logic en);
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

    function automatic logic [OUT_W-1:0] sat8(input logic [ACC_W-1:0] v);
        if ($signed(v) > SAT_MAX)
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if ($signed(v) < SAT_MIN)
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return v[OUT_W-1:0];
    endfunction

    assign streaming = (state_q == STREAM);
    assign isLast    = (idx_q == (sat_q ? 3'd3 : 3'd7));

    // State and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            sat_q      <= 1'b0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            sat_q      <= sat_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic. A capture is accepted either from IDLE or on the edge
    // that transfers the final byte; there it starts the next tile with no
    // bubble. Any other capture while streaming is dropped and flagged.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        sat_d      = sat_q;
        idx_d      = idx_q;
        overflow_d = 1'b0;
        latchTile  = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    latchTile = 1'b1;
                    state_d   = STREAM;
                    idx_d     = '0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (isLast) begin
                        idx_d = '0;
                        if (capture)
                            latchTile = 1'b1;
                        else
                            state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                if (capture && !(out_ready && isLast))
                    overflow_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ReLU is applied before storage, so saturation later sees the clamped value.
        if (latchTile) begin
            snap_d = {relu(c11, relu_en), relu(c10, relu_en),
                      relu(c01, relu_en), relu(c00, relu_en)};
            sat_d  = sat_en;
        end
    end

    // Byte selection from the stored snapshot. In 2-byte mode idx[2:1] picks
    // the result and idx[0] picks high (0) or low (1).
    always_comb begin
        sel       = sat_q ? idx_q[1:0] : idx_q[2:1];
        curResult = snap_q[sel];
        if (sat_q)
            curByte = sat8(curResult);
        else if (idx_q[0])
            curByte = curResult[OUT_W-1:0];
        else
            curByte = curResult[ACC_W-1 -: OUT_W];
    end

    assign out_data  = streaming ? curByte : '0;
    assign out_valid = streaming;
    assign busy      = streaming;
    assign out_last  = streaming && isLast;
    assign overflow  = overflow_q;

endmodule
